// File: rtl/uart_rx_ctrl.sv
// UART receive controller: host register file, receive FIFO,
// overflow tracking and a registered interrupt request.
module uart_rx_ctrl #(
    parameter int DEPTH_LOG2    = 3,
    parameter int DEFAULT_DELAY = 2604
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [11:0] delay,
    output logic        parity,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  irq_en;

    logic                  wr_ctrl;
    logic                  wr_dlo;
    logic                  wr_dhi;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  flush;
    logic                  push;
    logic                  drop;
    logic [CW-1:0]         count_nxt;
    logic [3:0]            cnt_disp;

    // Decode host strobes and resolve push/pop/flush interactions.
    always_comb begin
        wr_ctrl = we && (addr == 2'd1);
        wr_dlo  = we && (addr == 2'd2);
        wr_dhi  = we && (addr == 2'd3);
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        pop     = re && (addr == 2'd0) && !empty;
        flush   = wr_ctrl && wdata[0];
        // A pop in the same cycle frees the slot a full FIFO needs.
        push    = rx_ready && !flush && (!full || pop);
        drop    = rx_ready && !flush && full && !pop;
    end

    // Next occupancy; flush overrides any concurrent push or pop.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            // A dropped byte outranks a same-cycle clear request.
            if (drop) begin
                overflow <= 1'b1;
            end else if (wr_ctrl && wdata[6]) begin
                overflow <= 1'b0;
            end
        end
    end

    // FIFO storage carries no reset; only the bookkeeping does.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    // Host-writable configuration registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            parity <= 1'b0;
            delay  <= 12'(DEFAULT_DELAY);
        end else begin
            if (wr_ctrl) begin
                irq_en <= wdata[5];
                parity <= wdata[4];
            end
            if (wr_dlo) delay[7:0]  <= wdata;
            if (wr_dhi) delay[11:8] <= wdata[3:0];
        end
    end

    // Interrupt is a registered copy of the pending condition.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en && (!empty || overflow);
        end
    end

    // Status count field saturates for deep FIFOs.
    always_comb begin
        cnt_disp = 4'(count);
        if (32'(count) > 32'd15) cnt_disp = 4'hF;
    end

    // Combinational read mux.
    always_comb begin
        rdata = 8'h00;
        case (addr)
            2'd0: rdata = empty ? 8'h00 : mem[rd_ptr];
            2'd1: rdata = {!empty, overflow, irq_en, parity, cnt_disp};
            2'd2: rdata = delay[7:0];
            2'd3: rdata = {4'h0, delay[11:8]};
            default: rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model checked every
// cycle, plus directed sequences with literal expectations.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset_n;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic [7:0]  rdata;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [11:0] delay;
    logic        parity;
    logic        irq;

    int checks = 0;
    int failures = 0;

    uart_rx_ctrl #(.DEPTH_LOG2(3), .DEFAULT_DELAY(2604)) dut (
        .clock(clock), .reset_n(reset_n), .addr(addr), .wdata(wdata),
        .we(we), .re(re), .rdata(rdata), .rx_data(rx_data),
        .rx_ready(rx_ready), .delay(delay), .parity(parity), .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [7:0]  q[$];
    logic        m_ovf;
    logic        m_ien;
    logic        m_par;
    logic [11:0] m_dly;
    logic        m_irq;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_ien = 1'b0;
            m_par = 1'b0;
            m_dly = 12'd2604;
            m_irq = 1'b0;
        end else begin
            bit do_flush;
            bit do_pop;
            bit do_drop;
            m_irq = m_ien && (q.size() > 0 || m_ovf);
            do_flush = we && addr == 2'd1 && wdata[0];
            do_pop = re && addr == 2'd0 && q.size() > 0;
            do_drop = 1'b0;
            if (do_flush) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (rx_ready) begin
                    if (q.size() < DEPTH) q.push_back(rx_data);
                    else do_drop = 1'b1;
                end
            end
            if (we && addr == 2'd1) begin
                m_ien = wdata[5];
                m_par = wdata[4];
                if (wdata[6]) m_ovf = 1'b0;
            end
            if (do_drop) m_ovf = 1'b1;
            if (we && addr == 2'd2) m_dly[7:0] = wdata;
            if (we && addr == 2'd3) m_dly[11:8] = wdata[3:0];
        end
    end

    function automatic logic [7:0] model_rd(input logic [1:0] a);
        logic [7:0] r;
        int n;
        n = q.size();
        case (a)
            2'd0: r = (n > 0) ? q[0] : 8'h00;
            2'd1: r = {n > 0, m_ovf, m_ien, m_par, 4'(n)};
            2'd2: r = m_dly[7:0];
            default: r = {4'h0, m_dly[11:8]};
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (reset_n) begin
            chk("model_rdata", 32'(rdata), 32'(model_rd(addr)));
            chk("model_delay", 32'(delay), 32'(m_dly));
            chk("model_parity", 32'(parity), 32'(m_par));
            chk("model_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic drive(input logic [1:0] a, input logic w,
                         input logic [7:0] wd, input logic r,
                         input logic rx, input logic [7:0] rd);
        addr = a; we = w; wdata = wd; re = r;
        rx_ready = rx; rx_data = rd;
        @(posedge clock);
        #1;
        we = 1'b0; re = 1'b0; rx_ready = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        drive(2'd0, 1'b0, 8'h00, 1'b0, 1'b1, b);
    endtask

    task automatic pop();
        drive(2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        drive(a, 1'b1, d, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle();
        drive(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic expect_rd(input logic [1:0] a, input logic [7:0] e,
                             input string name);
        addr = a;
        #1;
        chk(name, 32'(rdata), 32'(e));
    endtask

    initial begin
        reset_n = 1'b0;
        addr = 2'd0; wdata = 8'h00; we = 1'b0; re = 1'b0;
        rx_data = 8'h00; rx_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset values
        expect_rd(2'd2, 8'h2C, "rst_dly_lo");
        expect_rd(2'd3, 8'h0A, "rst_dly_hi");
        expect_rd(2'd1, 8'h00, "rst_status");
        chk("rst_delay", 32'(delay), 32'd2604);
        chk("rst_parity", 32'(parity), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        // Simple push then ordered reads
        push(8'h41); push(8'h42); push(8'h43);
        expect_rd(2'd1, 8'h83, "st_three");
        expect_rd(2'd0, 8'h41, "rd_41"); pop();
        expect_rd(2'd0, 8'h42, "rd_42"); pop();
        expect_rd(2'd0, 8'h43, "rd_43"); pop();
        expect_rd(2'd1, 8'h00, "st_empty");
        expect_rd(2'd0, 8'h00, "rd_empty");
        pop();
        expect_rd(2'd1, 8'h00, "st_empty_pop");

        // Overflow: ninth byte lost
        for (int i = 0; i < 9; i++) push(8'(i));
        expect_rd(2'd1, 8'hC8, "st_ovf");
        for (int i = 0; i < 8; i++) begin
            expect_rd(2'd0, 8'(i), "rd_ovf_seq");
            pop();
        end
        expect_rd(2'd1, 8'h40, "st_ovf_empty");
        wr(2'd1, 8'h40);
        expect_rd(2'd1, 8'h00, "st_ovf_clr");

        // Full with same-cycle pop, across pointer wrap
        push(8'h90); push(8'h91); push(8'h92);
        pop(); pop(); pop();
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        expect_rd(2'd1, 8'h88, "st_full");
        expect_rd(2'd0, 8'h20, "rd_full_head");
        drive(2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h28);
        expect_rd(2'd1, 8'h88, "st_full_pp");
        for (int i = 1; i < 9; i++) begin
            expect_rd(2'd0, 8'h20 + 8'(i), "rd_wrap_seq");
            pop();
        end
        expect_rd(2'd1, 8'h00, "st_wrap_empty");

        // Interrupt timing
        wr(2'd1, 8'h20);
        push(8'h55);
        chk("irq_lag", 32'(irq), 32'd0);
        idle();
        chk("irq_set", 32'(irq), 32'd1);
        expect_rd(2'd0, 8'h55, "rd_55");
        pop();
        chk("irq_hold", 32'(irq), 32'd1);
        idle();
        chk("irq_clr", 32'(irq), 32'd0);

        // Delay/parity config and flush
        wr(2'd2, 8'h34); wr(2'd3, 8'h01); wr(2'd1, 8'h10);
        chk("cfg_delay", 32'(delay), 32'h134);
        chk("cfg_parity", 32'(parity), 32'd1);
        push(8'h77);
        expect_rd(2'd1, 8'h91, "st_pre_flush");
        wr(2'd1, 8'h11);
        expect_rd(2'd1, 8'h10, "st_flush");
        idle();
        chk("flush_irq", 32'(irq), 32'd0);

        // Flush beats concurrent push
        drive(2'd1, 1'b1, 8'h11, 1'b0, 1'b1, 8'hEE);
        expect_rd(2'd1, 8'h10, "st_flush_push");

        // Overflow set beats clear
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
        drive(2'd1, 1'b1, 8'h40, 1'b0, 1'b1, 8'hAA);
        expect_rd(2'd1, 8'hC8, "st_set_clr");
        wr(2'd1, 8'h41);
        expect_rd(2'd1, 8'h00, "st_flush_clr");

        // Push with empty read in the same cycle
        drive(2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h66);
        expect_rd(2'd1, 8'h81, "st_empty_rd_push");
        expect_rd(2'd0, 8'h66, "rd_66");
        pop();

        // Reset mid-transfer; strobes during reset ignored
        wr(2'd1, 8'h30);
        push(8'h12); push(8'h34);
        idle();
        chk("pre_rst_irq", 32'(irq), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_irq", 32'(irq), 32'd0);
        chk("async_delay", 32'(delay), 32'd2604);
        chk("async_parity", 32'(parity), 32'd0);
        drive(2'd1, 1'b1, 8'h31, 1'b0, 1'b1, 8'h99);
        drive(2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h98);
        reset_n = 1'b1;
        expect_rd(2'd1, 8'h00, "post_rst_status");
        expect_rd(2'd0, 8'h00, "post_rst_data");
        push(8'h5A);
        expect_rd(2'd0, 8'h5A, "post_rst_push");
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DEPTH_LOG2, 3, receive FIFO depth is 2**DEPTH_LOG2 bytes (default 8).
REQ-002 Parameter: DEFAULT_DELAY, 2604, bit-time reload value for the delay register at reset.
REQ-003 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: addr  input  2  host register select.
REQ-006 Port: wdata  input  8  host write data.
REQ-007 Port: we  input  1  host write strobe, one cycle per access.
REQ-008 Port: re  input  1  host read strobe, one cycle per access.
REQ-009 Port: rdata  output  8  host read data, combinational from addr and state.
REQ-010 Port: rx_data  input  8  received byte from the receiver.
REQ-011 Port: rx_ready  input  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-012 Port: delay  output  12  bit-time configuration driven to the receiver.
REQ-013 Port: parity  output  1  parity-enable configuration driven to the receiver.
REQ-014 Port: irq  output  1  interrupt request, level.

Function
REQ-015 Register map: 0 = data (R), 1 = status/control (R/W), 2 = delay[7:0] (R/W), 3 = delay[11:8] in bits 3:0 (R/W, bits 7:4 read 0).
REQ-016 Status read: bit7 nonempty, bit6 overflow, bit5 irq_en, bit4 parity, bits3:0 count (0..2**DEPTH_LOG2, saturating display at 15).
REQ-017 Control write (addr 1): bit5 -> irq_en, bit4 -> parity; bit6=1 clears overflow; bit0=1 flushes FIFO (count, pointers to 0).
REQ-018 Data read (addr 0): rdata = FIFO head byte when count>0, 0x00 when empty.
REQ-019 Pop: on re && addr==0 && count>0, read pointer advances (mod depth) and count decrements at that edge; empty read has no effect.
REQ-020 Push: on rx_ready, rx_data is written at write pointer, pointer advances (mod depth), count increments.
REQ-021 Full: rx_ready with count==depth and no same-cycle pop drops the byte, FIFO unchanged, overflow set to 1.
REQ-022 Full with same-cycle pop: push accepted, count stays at depth, overflow unchanged.
REQ-023 Simultaneous push and pop (count>0): both performed, count unchanged.
REQ-024 Push with count==0 and same-cycle data read: read ignored as empty, push accepted, count becomes 1.
REQ-025 Flush and push in same cycle: flush wins, byte dropped, count=0, overflow unchanged.
REQ-026 Overflow set and clear in same cycle: set wins.
REQ-027 Writes to addr 2/3 update delay at the edge; delay and parity outputs are the register values directly (no latency beyond the write edge).
REQ-028 re on addr 1..3 has no side effect; we on addr 0 is ignored.
REQ-029 irq = irq_en AND (count>0 OR overflow), registered, asserted the cycle after the condition becomes true and deasserted the cycle after it becomes false.
REQ-030 FIFO storage needs no reset; only pointers/count/flags are reset.

Reset
REQ-031 On reset_n low, immediately: count=0, pointers=0, overflow=0, irq_en=0, irq=0, parity=0, delay=DEFAULT_DELAY; reset mid-transfer discards buffered bytes.
REQ-032 Strobes (we, re, rx_ready) during reset are ignored; first edge after release operates normally.

Verification
REQ-033 Reset, read addr 2/3/1 -> 0x2C, 0x0A, 0x00; delay=2604, parity=0, irq=0.
REQ-034 Push 0x41,0x42,0x43, read addr 0 three times -> 0x41,0x42,0x43, status then 0x00, further read returns 0x00.
REQ-035 Push 9 bytes 0x00..0x08 without reads -> status 0xC8, reads return 0x00..0x07, byte 0x08 lost; write 0x40 to addr 1 -> overflow 0.
REQ-036 Count=8, rx_ready and data read same cycle -> byte accepted, count 8, overflow 0; drained order correct across pointer wrap.
REQ-037 Write 0x20 to addr 1, push 0x55 -> irq 1 next cycle; read addr 0 -> irq 0 the cycle after the pop.
REQ-038 Write 0x34 to addr 2, 0x01 to addr 3, 0x10 to addr 1 -> delay=0x134, parity=1; push then flush (0x11) -> count 0, irq 0.
